pipeline_hazard_controller: RTL

- Central stall/flush sequencer for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three conditions: load-use hazards, taken branches and multi-cycle data-memory waits.
- Provides saturating performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_hazard_controller.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and data-memory wait holds, plus saturating performance counters.
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic [3:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_wr_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_enable,
    output logic             idex_flush,
    output logic             exmem_enable,
    output logic             memwb_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_t;

    localparam logic [15:0]      TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        load_use, mem_stall;
    logic        hold, eval, timeout_hit, branch_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // R15 is the PC and is never forwarded from a load, so it cannot create a hazard.
    assign load_use = ex_is_load & ex_wr_en & (ex_rd != 4'hF) &
                      ((id_src1_used & (id_src1 == ex_rd)) |
                       (id_src2_used & (id_src2 == ex_rd)));
    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_nxt    = RUN;
        wait_cnt_nxt = 16'd0;
        hold         = 1'b0;
        eval         = 1'b0;
        timeout_hit  = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    hold         = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 16'd1;
                end else begin
                    eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_req || mem_ready) begin
                    eval = 1'b1;
                end else if (wait_cnt == TIMEOUT) begin
                    timeout_hit = 1'b1;
                    eval        = 1'b1;
                end else begin
                    hold         = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            default: ;
        endcase

        // While reset is held the pipeline sees plain run-mode controls.
        if (!reset) begin
            hold        = 1'b0;
            eval        = 1'b0;
            timeout_hit = 1'b0;
        end
        branch_fire = eval & branch_taken;

        pc_enable    = 1'b1;
        ifid_enable  = 1'b1;
        ifid_flush   = 1'b0;
        idex_enable  = 1'b1;
        idex_flush   = 1'b0;
        exmem_enable = 1'b1;
        memwb_flush  = 1'b0;
        if (hold) begin
            // EX is frozen, so any pending branch/load-use resurfaces on release.
            pc_enable    = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_flush  = 1'b1;
        end else if (branch_fire) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (eval && load_use) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= RUN;
            wait_cnt     <= 16'd0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_hit)
                mem_error <= 1'b1;
            if (!pc_enable)
                stall_cycles <= sat_inc(stall_cycles);
            if (branch_fire)
                flush_events <= sat_inc(flush_events);
        end
    end

endmodule
